// File: rtl/conv2_pkg.sv
// Shared sizing constants and helpers for the stage-2 bias/ReLU/quantise/pool block.
package conv2_pkg;

    localparam int IN_W  = 21;
    localparam int OUT_W = 16;
    localparam int ROW_W = 8;
    localparam int COL_H = 8;
    localparam int SHIFT = 4;

    localparam int COL_CNT_W = $clog2(ROW_W);
    localparam int ROW_CNT_W = $clog2(COL_H);
    localparam int SAT_MAX   = (1 << (OUT_W - 1)) - 1;

    // Operands are post-ReLU, so an unsigned compare is sufficient.
    function automatic logic [OUT_W-1:0] vmax(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv2_relu_quant.sv
// Registered bias add, arithmetic rescale, ReLU and saturation for one pixel per beat.
module conv2_relu_quant
    import conv2_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [IN_W-1:0]      in_data,
    input  logic signed [IN_W-1:0]      bias,
    input  logic [ROW_CNT_W-1:0]        row,
    input  logic [COL_CNT_W-1:0]        col,
    output logic                        q_valid,
    output logic [OUT_W-1:0]            q_value,
    output logic [ROW_CNT_W-1:0]        q_row,
    output logic [COL_CNT_W-1:0]        q_col
);

    localparam logic signed [IN_W:0] SAT_R = (IN_W + 1)'(SAT_MAX);

    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;
    logic [OUT_W-1:0]     clipped;

    // One extra bit of headroom keeps the bias add from ever overflowing.
    always_comb begin
        sum     = {in_data[IN_W-1], in_data} + {bias[IN_W-1], bias};
        shifted = sum >>> SHIFT;
        if (shifted[IN_W]) begin
            clipped = '0;
        end else if (shifted > SAT_R) begin
            clipped = OUT_W'(SAT_MAX);
        end else begin
            clipped = shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_value <= '0;
            q_row   <= '0;
            q_col   <= '0;
        end else begin
            q_valid <= in_valid;
            if (in_valid) begin
                q_value <= clipped;
                q_row   <= row;
                q_col   <= col;
            end
        end
    end

endmodule

// File: rtl/conv2_relu_pool.sv
// Per-channel bias/ReLU/quantise stage followed by 2x2 max pooling over a raster stream.
module conv2_relu_pool
    import conv2_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic signed [IN_W-1:0]  bias,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic                    frame_done
);

    localparam logic [COL_CNT_W-1:0] COL_LAST = COL_CNT_W'(ROW_W - 1);
    localparam logic [ROW_CNT_W-1:0] ROW_LAST = ROW_CNT_W'(COL_H - 1);

    logic [COL_CNT_W-1:0]   col;
    logic [ROW_CNT_W-1:0]   row;
    logic signed [IN_W-1:0] bias_q;
    logic signed [IN_W-1:0] bias_eff;
    logic                   first_px;

    logic                   a_valid;
    logic [OUT_W-1:0]       a_value;
    logic [ROW_CNT_W-1:0]   a_row;
    logic [COL_CNT_W-1:0]   a_col;

    logic [OUT_W-1:0]       h_max;
    logic [OUT_W-1:0]       line_buf [ROW_W/2];
    logic [OUT_W-1:0]       pair_max;
    logic [OUT_W-1:0]       win_max;

    // Pixel (0,0) must see the live bias port; every later pixel uses the latched copy.
    always_comb begin
        first_px = (row == '0) && (col == '0);
        bias_eff = first_px ? bias : bias_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            bias_q <= '0;
        end else if (in_valid) begin
            if (first_px) begin
                bias_q <= bias;
            end
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    conv2_relu_quant u_quant (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .bias     (bias_eff),
        .row      (row),
        .col      (col),
        .q_valid  (a_valid),
        .q_value  (a_value),
        .q_row    (a_row),
        .q_col    (a_col)
    );

    always_comb begin
        pair_max = vmax(h_max, a_value);
        win_max  = vmax(line_buf[a_col[COL_CNT_W-1:1]], pair_max);
    end

    always_ff @(posedge clk) begin
        if (a_valid && a_col[0] && !a_row[0]) begin
            line_buf[a_col[COL_CNT_W-1:1]] <= pair_max;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_max      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (a_valid) begin
                if (!a_col[0]) begin
                    h_max <= a_value;
                end else if (a_row[0]) begin
                    out_data   <= win_max;
                    out_valid  <= 1'b1;
                    frame_done <= (a_row == ROW_LAST) && (a_col == COL_LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2_relu_pool.sv
// Directed-vector bench for conv2_relu_pool: constant, ramp, gapped, reset and back-to-back frames.
module tb_conv2_relu_pool;
    import conv2_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic signed [IN_W-1:0] in_data = '0;
    logic signed [IN_W-1:0] bias = '0;
    logic                   out_valid;
    logic [OUT_W-1:0]       out_data;
    logic                   frame_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fd_stray = 0;

    logic [OUT_W-1:0] q_data [$];
    int               q_cyc  [$];
    logic             q_fd   [$];
    int               exp_cyc[$];

    conv2_relu_pool dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .bias       (bias),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            q_data.push_back(out_data);
            q_cyc.push_back(cyc);
            q_fd.push_back(frame_done);
        end else if (frame_done) begin
            fd_stray++;
        end
    end

    function automatic logic [OUT_W-1:0] ramp_exp(input int w);
        return OUT_W'((2 * (w / 4) + 1) * 8 + 2 * (w % 4) + 1);
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_cyc.delete();
        q_fd.delete();
        exp_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = IN_W'($urandom);
        end
    endtask

    // Drives npix raster pixels; records the expected output cycle of each window.
    task automatic drive_frame(input bit ramp, input logic signed [IN_W-1:0] cval,
                               input logic signed [IN_W-1:0] b0,
                               input logic signed [IN_W-1:0] b1,
                               input bit gaps, input int npix);
        for (int p = 0; p < npix; p++) begin
            if (gaps) begin
                for (int k = 0; k < 4 && $urandom_range(1, 0) == 1; k++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    in_data  = IN_W'($urandom);
                    bias     = b1;
                end
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = ramp ? IN_W'(16 * p) : cval;
            bias     = (p == 0) ? b0 : b1;
            if ((p / 8) % 2 == 1 && p % 2 == 1) exp_cyc.push_back(cyc + 2);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = IN_W'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: out_valid=%b frame_done=%b out_data=%0d, want 0/0/0",
                     out_valid, frame_done, out_data);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_const_frames();
        logic signed [IN_W-1:0] d_t [4] = '{21'sd160, -21'sd500, -21'sd500, 21'sd1048575};
        logic signed [IN_W-1:0] b_t [4] = '{21'sd0, 21'sd0, 21'sd660, 21'sd1048575};
        logic signed [IN_W-1:0] b2_t[4] = '{21'sd0, 21'sd0, -21'sd3000, 21'sd1048575};
        logic [OUT_W-1:0]       e_t [4] = '{16'd10, 16'd0, 16'd10, 16'd32767};
        for (int t = 0; t < 4; t++) begin
            clear_q();
            drive_frame(1'b0, d_t[t], b_t[t], b2_t[t], 1'b0, 64);
            idle(4);
            vectors++;
            if (q_data.size() != 16) begin
                miscompares++;
                $display("FAIL const%0d_count: got %0d outputs, want 16", t, q_data.size());
            end
            for (int i = 0; i < 16 && i < q_data.size(); i++) begin
                vectors++;
                if (q_data[i] !== e_t[t] || q_cyc[i] != exp_cyc[i] || q_fd[i] !== (i == 15)) begin
                    miscompares++;
                    $display("FAIL const%0d_out%0d: data=%0d cyc=%0d fd=%b, want data=%0d cyc=%0d fd=%b",
                             t, i, q_data[i], q_cyc[i], q_fd[i], e_t[t], exp_cyc[i], i == 15);
                end
            end
        end
    endtask

    task automatic test_ramp(input bit gaps);
        clear_q();
        drive_frame(1'b1, '0, '0, '0, gaps, 64);
        idle(4);
        vectors++;
        if (q_data.size() != 16) begin
            miscompares++;
            $display("FAIL ramp_gaps%0d_count: got %0d outputs, want 16", gaps, q_data.size());
        end
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            vectors++;
            if (q_data[i] !== ramp_exp(i) || q_cyc[i] != exp_cyc[i] || q_fd[i] !== (i == 15)) begin
                miscompares++;
                $display("FAIL ramp_gaps%0d_out%0d: data=%0d cyc=%0d fd=%b, want data=%0d cyc=%0d fd=%b",
                         gaps, i, q_data[i], q_cyc[i], q_fd[i], ramp_exp(i), exp_cyc[i], i == 15);
            end
        end
    endtask

    task automatic test_reset_mid_frame_back_to_back();
        clear_q();
        drive_frame(1'b1, '0, '0, '0, 1'b0, 37);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = IN_W'(16 * 37);
        vectors++;
        if (q_data.size() != 8 || out_data !== 16'd31) begin
            miscompares++;
            $display("FAIL pre_reset: got %0d outputs last=%0d, want 8 outputs last=31",
                     q_data.size(), out_data);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: out_valid=%b frame_done=%b out_data=%0d, want 0/0/0",
                     out_valid, frame_done, out_data);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        clear_q();
        drive_frame(1'b1, '0, '0, '0, 1'b0, 64);
        drive_frame(1'b1, '0, '0, '0, 1'b0, 64);
        idle(4);
        vectors++;
        if (q_data.size() != 32 || fd_stray != 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d outputs stray_fd=%0d, want 32 outputs stray_fd=0",
                     q_data.size(), fd_stray);
        end
        for (int i = 0; i < 32 && i < q_data.size(); i++) begin
            vectors++;
            if (q_data[i] !== ramp_exp(i % 16) || q_cyc[i] != exp_cyc[i] ||
                q_fd[i] !== (i % 16 == 15)) begin
                miscompares++;
                $display("FAIL b2b_out%0d: data=%0d cyc=%0d fd=%b, want data=%0d cyc=%0d fd=%b",
                         i, q_data[i], q_cyc[i], q_fd[i], ramp_exp(i % 16), exp_cyc[i], i % 16 == 15);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const_frames();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_reset_mid_frame_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv2_relu_pool.md
Name: conv2_relu_pool

Overview:
- Stage directly downstream of the stage-2 three-way adder tree. Consumes its 21-bit signed convolution sums, one per cycle, in raster order.
- Per pixel it adds bias, applies ReLU, rescales and saturates the result.
- It then performs 2x2 max pooling and emits one pooled feature per 2x2 window to the next layer's input buffer.
- One instance handles one feature map channel.

Parameters:
- IN_W, 21, width of signed convolution sum input
- OUT_W, 16, width of signed pooled output (always non-negative)
- ROW_W, 8, conv feature map width in pixels (even, >=2)
- COL_H, 8, conv feature map height in pixels (even, >=2)
- SHIFT, 4, arithmetic right shift applied after bias add

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_data carries a valid pixel this cycle
- in_data  in  IN_W  signed conv sum (adder-tree output)
- bias  in  IN_W  signed channel bias
- out_valid  out  1  one-cycle pulse, out_data is a pooled result
- out_data  out  OUT_W  pooled feature
- frame_done  out  1  one-cycle pulse coincident with the last pooled output of a frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a clk edge, the following clear to 0:
  - out_valid, out_data, frame_done
  - row/col counters, stage-A register, h_max, bias_q
  - Line buffer contents need not clear.
- Reset mid-frame discards the partial frame. The first in_valid after release is pixel (0,0).
- Gaps: in_valid may be low for any number of cycles between pixels. Counters and pipeline state hold during a gap, and the result is identical to gapless input.
- Bias latch: bias_q loads on the in_valid beat at (row 0, col 0); that beat uses the bias port value directly. All other beats use bias_q.
- Stage A (registered, 1 cycle):
  - s = in_data + bias, computed at IN_W+1 bits sign-extended, so the add never overflows.
  - r = s >>> SHIFT.
  - r < 0 gives 0 (ReLU). r > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1. Otherwise r.
  - Stage A passes its valid, row and col alongside the value.
- Stage B (pooling, on a stage-A valid beat at (row, col)):
  - Even col: h_max <= value.
  - Odd col, even row: line_buf[col>>1] <= max(h_max, value).
  - Odd col, odd row: out_data <= max(line_buf[col>>1], h_max, value) and out_valid <= 1.
  - Line buffer depth ROW_W/2, width OUT_W.
- Latency: out_valid asserts exactly 2 clk edges after the in_valid beat carrying the bottom-right pixel of a window.
- Output hold: out_data holds its last value when out_valid=0.
- Counters:
  - col wraps ROW_W-1 to 0 and increments row.
  - row wraps COL_H-1 to 0, which starts a new frame.
  - Back-to-back frames are allowed with no gap.
- Frame end: frame_done=1 together with the out_valid for window (COL_H/2-1, ROW_W/2-1).
- Output count: (ROW_W/2)*(COL_H/2) outputs per frame, in raster window order.
- Back-pressure: none. The downstream consumer must accept every out_valid pulse.

Decomposition:
- Shared package conv2_pkg:
  - Constants IN_W, OUT_W, ROW_W, COL_H, SHIFT.
  - Derived constants COL_CNT_W = clog2(ROW_W), ROW_CNT_W = clog2(COL_H), SAT_MAX = 2^(OUT_W-1)-1.
- Sub-module conv2_relu_quant: the registered bias-add, shift, ReLU and saturate stage (Stage A), including its valid/row/col passthrough.
- The pooling logic, line buffer and counters stay in conv2_relu_pool.

Test Plan:
- Uniform: ROW_W=COL_H=8, bias=0, all in_data=160 gapless -> 16 out_valid pulses, each out_data=10. frame_done only on the 16th pulse, which comes 2 cycles after the 64th input.
- ReLU and bias:
  - All in_data=-500, bias=0 -> 16 outputs of 0.
  - All in_data=-500, bias=660 -> 16 outputs of 10 (bias latched from pixel 0 even if the port changes mid-frame).
- Saturation: all in_data=1048575, bias=1048575 -> 16 outputs of 32767, with no wrap to negative.
- Ramp: in_data=16*(8*row+col), bias=0 -> outputs 9,11,13,15,25,...,63, i.e. (2R+1)*8+(2C+1).
- Gaps: ramp frame with in_valid randomly low ~50% -> same 16-value sequence. Each out_valid comes 2 cycles after its window's last valid beat.
- Reset mid-frame and back-to-back:
  - Assert rst_n=0 at pixel 37 for 1 cycle -> outputs go 0 immediately.
  - A following full ramp frame gives the exact 16-value sequence.
  - A second, immediately following frame gives the same 16 values and a second frame_done.
